vector_alu_pipe: RTL and testbench

//  Parametrised, pipelined SIMD integer ALU; next generation of vector_alu for the vector unit.

---
 rtl/valu_pkg.sv | 35 +++
 rtl/valu_lane.sv | 67 ++++++
 rtl/vector_alu_pipe.sv | 111 +++++++++++
 tb/tb_vector_alu_pipe.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/valu_pkg.sv
// Shared definitions for the pipelined SIMD ALU: opcode encodings and opcode
// classification helpers. Optional feature macro used by this bundle: VALU_SAT_EN.
package valu_pkg;

  localparam int VALU_OPW = 5;

  typedef enum logic [VALU_OPW-1:0] {
    VNOP    = 5'h00,
    VSPLAT  = 5'h01,
    VADD    = 5'h03,
    VSUB    = 5'h04,
    VMIN    = 5'h05,
    VMAX    = 5'h06,
    VAND    = 5'h07,
    VOR     = 5'h08,
    VXOR    = 5'h09,
    VSLL    = 5'h0A,
    VSRA    = 5'h0B,
    VADDS   = 5'h0C,
    VREDSUM = 5'h10,
    VDOT    = 5'h11
  } valu_op_e;

  // Cross-lane ops write rout only; vout is forced to zero for them.
  function automatic logic is_reduction(input logic [VALU_OPW-1:0] op);
    return (op == VREDSUM) || (op == VDOT);
  endfunction

  // Any encoding outside the table above is flagged as illegal.
  function automatic logic is_legal(input logic [VALU_OPW-1:0] op);
    return op inside {VNOP, VSPLAT, VADD, VSUB, VMIN, VMAX, VAND, VOR, VXOR,
                      VSLL, VSRA, VADDS, VREDSUM, VDOT};
  endfunction

endpackage

// File: rtl/valu_lane.sv
// Combinational single-lane operation unit. Produces the lane result and the
// truncated a*b product consumed by the VDOT reduction in the top level.
// VALU_SAT_EN makes VADD/VSUB/VADDS saturate to the signed DW-bit range.
module valu_lane
  import valu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [VALU_OPW-1:0] op_i,
  input  logic [DW-1:0]       a_i,
  input  logic [DW-1:0]       b_i,
  input  logic [DW-1:0]       r1_i,
  input  logic [7:0]          imm_i,
  output logic [DW-1:0]       res_o,
  output logic [DW-1:0]       prod_o
);

  logic [DW-1:0] addend;
  logic [DW-1:0] sum_w;
  logic [DW-1:0] diff_w;
  logic [DW-1:0] sum_r;
  logic [DW-1:0] diff_r;
  logic          big_shift;

  // VADDS reuses the lane adder with the scalar as second operand.
  assign addend    = (op_i == VADDS) ? r1_i : b_i;
  assign sum_w     = a_i + addend;
  assign diff_w    = a_i - b_i;
  assign big_shift = 32'(imm_i) >= 32'(DW);
  assign prod_o    = a_i * b_i;

`ifdef VALU_SAT_EN
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  logic sum_ovf;
  logic diff_ovf;

  // Signed overflow: result sign disagrees with what the operand signs allow.
  assign sum_ovf  = (a_i[DW-1] == addend[DW-1]) && (sum_w[DW-1] != a_i[DW-1]);
  assign diff_ovf = (a_i[DW-1] != b_i[DW-1]) && (diff_w[DW-1] != a_i[DW-1]);
  assign sum_r    = sum_ovf  ? (a_i[DW-1] ? SMIN : SMAX) : sum_w;
  assign diff_r   = diff_ovf ? (a_i[DW-1] ? SMIN : SMAX) : diff_w;
`else
  assign sum_r  = sum_w;
  assign diff_r = diff_w;
`endif

  // Lane result select; undefined and reduction opcodes leave the lane at zero.
  always_comb begin
    // NOTE: defaulting the output first means no path leaves it unassigned, so no latch is inferred.
    res_o = '0;
    case (valu_op_e'(op_i))
      VSPLAT:      res_o = r1_i;
      VADD, VADDS: res_o = sum_r;
      VSUB:        res_o = diff_r;
      VMIN:        res_o = ($signed(a_i) < $signed(b_i)) ? a_i : b_i;
      VMAX:        res_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
      VAND:        res_o = a_i & b_i;
      VOR:         res_o = a_i | b_i;
      VXOR:        res_o = a_i ^ b_i;
      VSLL:        res_o = big_shift ? '0 : (a_i << imm_i);
      VSRA:        res_o = big_shift ? {DW{a_i[DW-1]}} : DW'($signed(a_i) >>> imm_i);
      default:     res_o = '0;
    endcase
  end

endmodule

// File: rtl/vector_alu_pipe.sv
// Pipelined SIMD integer ALU: LANES x DW-bit lanes plus cross-lane reductions,
// STAGES valid-tagged registers with a global stall (en). Stage 1 captures the
// full combinational result; later stages only delay it.
// Optional feature macro: VALU_SAT_EN (signed saturation for VADD/VSUB/VADDS).
module vector_alu_pipe
  import valu_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DW     = 32,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  input  logic [DW-1:0]       v1 [LANES-1:0],
  input  logic [DW-1:0]       v2 [LANES-1:0],
  input  logic [DW-1:0]       r1,
  input  logic [DW-1:0]       r2,
  input  logic [VALU_OPW-1:0] op,
  input  logic [7:0]          imm,
  output logic                out_valid,
  output logic [VALU_OPW-1:0] out_op,
  output logic                out_illegal,
  output logic [DW-1:0]       vout [LANES-1:0],
  output logic [DW-1:0]       rout
);

  typedef struct packed {
    logic                       valid;
    logic [VALU_OPW-1:0]        op;
    logic                       illegal;
    logic [LANES-1:0][DW-1:0]   vout;
    logic [DW-1:0]              rout;
  } stage_t;

  logic [DW-1:0] lane_res  [LANES];
  logic [DW-1:0] lane_prod [LANES];
  logic [DW-1:0] red_sum;
  logic [DW-1:0] dot_sum;
  stage_t        stage_d;
  stage_t        stage_q [STAGES];

  // r2 is reserved on the interface; no current opcode reads it.
  logic unused_r2;
  assign unused_r2 = ^r2;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    valu_lane #(.DW(DW)) u_lane (
      .op_i   (op),
      .a_i    (v1[g]),
      .b_i    (v2[g]),
      .r1_i   (r1),
      .imm_i  (imm),
      .res_o  (lane_res[g]),
      .prod_o (lane_prod[g])
    );
    assign vout[g] = stage_q[STAGES-1].vout[g];
  end

  // Cross-lane sums; both wrap at DW bits.
  always_comb begin
    red_sum = '0;
    dot_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      // NOTE: blocking assignments in combinational logic so each iteration sees the running sum.
      red_sum = red_sum + v1[i];
      dot_sum = dot_sum + lane_prod[i];
    end
  end

  // Assemble the stage-1 entry; a bubble enters as an all-zero entry.
  always_comb begin
    stage_d = '0;
    if (in_valid) begin
      stage_d.valid   = 1'b1;
      stage_d.op      = op;
      stage_d.illegal = !is_legal(op);
      for (int i = 0; i < LANES; i++) begin
        stage_d.vout[i] = is_reduction(op) ? '0 : lane_res[i];
      end
      if (op == VREDSUM) begin
        stage_d.rout = red_sum;
      end else if (op == VDOT) begin
        stage_d.rout = dot_sum;
      end
    end
  end

  // Pipeline registers: advance together when en is high, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every stage is a control-bearing register (valid tag), not a memory, so all are reset.
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else if (en) begin
      // NOTE: non-blocking assignments so every stage shifts from its pre-edge value.
      stage_q[0] <= stage_d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_valid   = stage_q[STAGES-1].valid;
  assign out_op      = stage_q[STAGES-1].op;
  assign out_illegal = stage_q[STAGES-1].illegal;
  assign rout        = stage_q[STAGES-1].rout;

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Self-checking bench for vector_alu_pipe (LANES=4, DW=32, STAGES=2).
// A spec-level reference model computes each result with plain arithmetic and
// a queue stands in for the in-flight pipeline contents.
module tb_vector_alu_pipe;
  import valu_pkg::*;

  localparam int LANES  = 4;
  localparam int DW     = 32;
  localparam int STAGES = 2;

  typedef logic [LANES-1:0][DW-1:0] vec_t;

  typedef struct packed {
    logic             valid;
    logic [4:0]       op;
    logic             illegal;
    vec_t             vout;
    logic [DW-1:0]    rout;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] v1 [LANES-1:0];
  logic [DW-1:0] v2 [LANES-1:0];
  logic [DW-1:0] r1 = '0;
  logic [DW-1:0] r2 = '0;
  logic [4:0]    op = '0;
  logic [7:0]    imm = '0;
  logic          out_valid;
  logic [4:0]    out_op;
  logic          out_illegal;
  logic [DW-1:0] vout [LANES-1:0];
  logic [DW-1:0] rout;

  res_t pipe_q [$];
  int   vectors = 0;
  int   miscompares = 0;

  vector_alu_pipe #(.LANES(LANES), .DW(DW), .STAGES(STAGES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .in_valid    (in_valid),
    .v1          (v1),
    .v2          (v2),
    .r1          (r1),
    .r2          (r2),
    .op          (op),
    .imm         (imm),
    .out_valid   (out_valid),
    .out_op      (out_op),
    .out_illegal (out_illegal),
    .vout        (vout),
    .rout        (rout)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] arith(input longint s);
`ifdef VALU_SAT_EN
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return 32'(s);
  endfunction

  function automatic res_t model(input logic [4:0] o, input vec_t a, input vec_t b,
                                 input logic [DW-1:0] s, input logic [7:0] im);
    res_t r;
    longint unsigned acc;
    longint x;
    r = '0;
    r.valid = 1'b1;
    r.op = o;
    acc = 0;
    for (int i = 0; i < LANES; i++) begin
      case (o)
        5'h00: ;
        5'h01: r.vout[i] = s;
        5'h03: r.vout[i] = arith(longint'(int'(a[i])) + longint'(int'(b[i])));
        5'h04: r.vout[i] = arith(longint'(int'(a[i])) - longint'(int'(b[i])));
        5'h05: r.vout[i] = (int'(a[i]) < int'(b[i])) ? a[i] : b[i];
        5'h06: r.vout[i] = (int'(a[i]) > int'(b[i])) ? a[i] : b[i];
        5'h07: r.vout[i] = a[i] & b[i];
        5'h08: r.vout[i] = a[i] | b[i];
        5'h09: r.vout[i] = a[i] ^ b[i];
        5'h0A: r.vout[i] = (im >= 8'd32) ? 32'h0 : (a[i] << im);
        5'h0B: begin
          x = longint'(int'(a[i]));
          if (im >= 8'd32) r.vout[i] = a[i][31] ? 32'hFFFF_FFFF : 32'h0;
          else             r.vout[i] = 32'(x >>> im);
        end
        5'h0C: r.vout[i] = arith(longint'(int'(a[i])) + longint'(int'(s)));
        5'h10: acc = acc + 64'(a[i]);
        5'h11: acc = acc + 64'(a[i]) * 64'(b[i]);
        default: r.illegal = 1'b1;
      endcase
    end
    if (o == 5'h10 || o == 5'h11) r.rout = 32'(acc);
    return r;
  endfunction

  function automatic res_t observed();
    res_t o;
    o.valid   = out_valid;
    o.op      = out_op;
    o.illegal = out_illegal;
    o.rout    = rout;
    for (int i = 0; i < LANES; i++) o.vout[i] = vout[i];
    return o;
  endfunction

  function automatic void reset_model();
    pipe_q.delete();
    for (int i = 0; i < STAGES; i++) pipe_q.push_back('0);
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 9))
        0:       v[i] = 32'h7FFF_FFFF;
        1:       v[i] = 32'h8000_0000;
        2:       v[i] = 32'hFFFF_FFFF;
        default: v[i] = $urandom;
      endcase
    end
    return v;
  endfunction

  // Drive one cycle at the falling edge, let the rising edge pass, update the
  // model if the pipe advanced, and leave time at posedge+1 for sampling.
  task automatic apply(input logic e, input logic val, input logic [4:0] o,
                       input vec_t a, input vec_t b, input logic [DW-1:0] s,
                       input logic [7:0] im);
    res_t z;
    z = '0;
    @(negedge clk);
    en = e;
    in_valid = val;
    op = o;
    for (int i = 0; i < LANES; i++) begin
      v1[i] = a[i];
      v2[i] = b[i];
    end
    r1 = s;
    r2 = $urandom;
    imm = im;
    @(posedge clk);
    if (e) begin
      pipe_q.push_back(val ? model(o, a, b, s, im) : z);
      void'(pipe_q.pop_front());
    end
    #1;
  endtask

  task automatic bubble();
    apply(1'b1, 1'b0, 5'h00, '0, '0, '0, 8'h0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    res_t o;
    rst_n = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      v1[i] = '0;
      v2[i] = '0;
    end
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    o = observed();
    vectors++;
    if (o !== res_t'(0)) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected 0", o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_vadd();
    vec_t a, b, expv;
    res_t o;
    a = {32'd4, 32'd3, 32'd2, 32'd1};
    b = {32'd40, 32'd30, 32'd20, 32'd10};
    expv = {32'd44, 32'd33, 32'd22, 32'd11};
    apply(1'b1, 1'b1, VADD, a, b, 32'h0, 8'h0);
    o = observed();
    vectors++;
    if (o.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL vadd_latency: out_valid=%b after 1 cycle, expected 0", o.valid);
    end
    bubble();
    o = observed();
    vectors++;
    if (o.valid !== 1'b1 || o.op !== 5'h03 || o.vout !== expv || o.rout !== 32'h0 || o.illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL vadd_result: got v=%b op=%h vout=%h rout=%h ill=%b expected v=1 op=03 vout=%h rout=0 ill=0",
               o.valid, o.op, o.vout, o.rout, o.illegal, expv);
    end
  endtask

  task automatic test_reduction_shift();
    vec_t a, z;
    res_t o;
    z = '0;
    a = {32'hFFFF_FFFF, 32'd3, 32'd2, 32'd1};
    apply(1'b1, 1'b1, VREDSUM, a, rand_vec(), $urandom, 8'h0);
    a = {32'd5, 32'h1234_5678, 32'h7000_0000, 32'h8000_0000};
    apply(1'b1, 1'b1, VSRA, a, rand_vec(), $urandom, 8'd40);
    o = observed();
    vectors++;
    if (o.rout !== 32'd5 || o.vout !== z || o.op !== 5'h10) begin
      miscompares++;
      $display("FAIL redsum_wrap: rout=%h vout=%h op=%h expected rout=5 vout=0 op=10", o.rout, o.vout, o.op);
    end
    apply(1'b1, 1'b1, VSLL, a, rand_vec(), $urandom, 8'd40);
    o = observed();
    vectors++;
    if (o.vout[0] !== 32'hFFFF_FFFF || o.vout[1] !== 32'h0 || o.rout !== 32'h0) begin
      miscompares++;
      $display("FAIL vsra_big_imm: lane0=%h lane1=%h rout=%h expected ffffffff 0 0", o.vout[0], o.vout[1], o.rout);
    end
    bubble();
    o = observed();
    vectors++;
    if (o.vout !== z || o.op !== 5'h0A) begin
      miscompares++;
      $display("FAIL vsll_big_imm: vout=%h op=%h expected 0 op=0a", o.vout, o.op);
    end
    bubble();
    o = observed();
    vectors++;
    if (o !== pipe_q[0]) begin
      miscompares++;
      $display("FAIL drain_after_shift: got %h expected %h", o, pipe_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    res_t o, frozen;
    apply(1'b1, 1'b1, VADD, rand_vec(), rand_vec(), $urandom, 8'h0);
    o = observed();
    vectors++;
    if (o !== pipe_q[0]) begin
      miscompares++;
      $display("FAIL b2b_vadd_in: got %h expected %h", o, pipe_q[0]);
    end
    apply(1'b1, 1'b1, VSUB, rand_vec(), rand_vec(), $urandom, 8'h0);
    frozen = observed();
    vectors++;
    if (frozen !== pipe_q[0]) begin
      miscompares++;
      $display("FAIL b2b_vadd_out: got %h expected %h", frozen, pipe_q[0]);
    end
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, VXOR, rand_vec(), rand_vec(), $urandom, 8'h0);
      o = observed();
      vectors++;
      if (o !== frozen || o !== pipe_q[0]) begin
        miscompares++;
        $display("FAIL b2b_stall_hold%0d: got %h expected %h", k, o, frozen);
      end
    end
    bubble();
    apply(1'b1, 1'b1, VDOT, rand_vec(), rand_vec(), $urandom, 8'h0);
    for (int k = 0; k < 3; k++) begin
      o = observed();
      vectors++;
      if (o !== pipe_q[0]) begin
        miscompares++;
        $display("FAIL b2b_drain%0d: got %h expected %h", k, o, pipe_q[0]);
      end
      bubble();
    end
  endtask

  task automatic test_illegal();
    res_t o;
    vec_t z;
    z = '0;
    apply(1'b1, 1'b1, 5'h1F, rand_vec(), rand_vec(), $urandom, 8'h3);
    bubble();
    o = observed();
    vectors++;
    if (o.valid !== 1'b1 || o.illegal !== 1'b1 || o.vout !== z || o.rout !== 32'h0 || o.op !== 5'h1F) begin
      miscompares++;
      $display("FAIL illegal_op: v=%b ill=%b vout=%h rout=%h op=%h expected 1 1 0 0 1f",
               o.valid, o.illegal, o.vout, o.rout, o.op);
    end
  endtask

  task automatic test_reset_midstream();
    res_t o;
    apply(1'b1, 1'b1, VADD, rand_vec(), rand_vec(), $urandom, 8'h0);
    apply(1'b1, 1'b1, VMAX, rand_vec(), rand_vec(), $urandom, 8'h0);
    #2;
    rst_n = 1'b0;
    #1;
    o = observed();
    vectors++;
    if (o !== res_t'(0)) begin
      miscompares++;
      $display("FAIL reset_midstream_clear: got %h expected 0", o);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    for (int k = 0; k < 3; k++) begin
      bubble();
      o = observed();
      vectors++;
      if (o.valid !== 1'b0 || o !== pipe_q[0]) begin
        miscompares++;
        $display("FAIL reset_no_stale%0d: got %h expected 0", k, o);
      end
    end
  endtask

  task automatic test_saturation();
    vec_t a, b;
    res_t o;
    logic [DW-1:0] want;
`ifdef VALU_SAT_EN
    want = 32'h7FFF_FFFF;
`else
    want = 32'h8000_0000;
`endif
    a = {32'd7, 32'h8000_0000, 32'h7FFF_FFF0, 32'h7FFF_FFFF};
    b = {32'd1, 32'd1, 32'h10, 32'd1};
    apply(1'b1, 1'b1, VADD, a, b, 32'h0, 8'h0);
    apply(1'b1, 1'b1, VSUB, a, b, 32'h0, 8'h0);
    o = observed();
    vectors++;
    if (o.vout[0] !== want) begin
      miscompares++;
      $display("FAIL vadd_overflow: lane0=%h expected %h", o.vout[0], want);
    end
    apply(1'b1, 1'b1, VADDS, a, b, 32'h7FFF_FFFF, 8'h0);
    for (int k = 0; k < 3; k++) begin
      o = observed();
      vectors++;
      if (o !== pipe_q[0]) begin
        miscompares++;
        $display("FAIL sat_model%0d: got %h expected %h", k, o, pipe_q[0]);
      end
      bubble();
    end
  endtask

  task automatic test_random();
    logic [4:0] ops [16];
    res_t o;
    ops = '{VNOP, VSPLAT, VADD, VSUB, VMIN, VMAX, VAND, VOR, VXOR, VSLL, VSRA,
            VADDS, VREDSUM, VDOT, 5'h02, 5'h1F};
    for (int k = 0; k < 400; k++) begin
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            ($urandom_range(0, 15) == 0) ? 5'($urandom) : ops[$urandom_range(0, 15)],
            rand_vec(), rand_vec(), $urandom,
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31)));
      o = observed();
      vectors++;
      if (o !== pipe_q[0]) begin
        miscompares++;
        $display("FAIL random_%0d: got %h expected %h", k, o, pipe_q[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vadd();
    test_reduction_shift();
    test_back_to_back();
    test_illegal();
    test_reset_midstream();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
